// File: rtl/otfc_pkg.sv
// otfc_pkg: state encoding and digit codes shared by the on-the-fly quotient converter
package otfc_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} otfc_state_t;
    localparam logic [1:0] DIG_ZERO  = 2'b00;
    localparam logic [1:0] DIG_PLUS  = 2'b10;
    localparam logic [1:0] DIG_MINUS = 2'b01;
endpackage

// File: rtl/rem_sign_zero.sv
// rem_sign_zero: sign and zero status of a carry-save remainder; zero is found without carry propagation
module rem_sign_zero #(
    parameter int RW = 10
) (
    input  logic [RW-1:0] s,
    input  logic [RW-1:0] c,
    output logic          neg,
    output logic          zero
);
    assign neg  = |((s + c) & {1'b1, {(RW-1){1'b0}}});
    assign zero = (s ^ c) == {s[RW-2:0] | c[RW-2:0], 1'b0};
endmodule

// File: rtl/otfc_quotient_resolver.sv
// otfc_quotient_resolver: radix-2 on-the-fly Q/QM converter with remainder-based final selection; sticky output enabled by OTFC_STICKY_EN
module otfc_quotient_resolver
    import otfc_pkg::*;
#(
    parameter int N  = 8,
    parameter int RW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    input  logic          dig_valid,
    output logic          dig_ready,
    input  logic          dig_p,
    input  logic          dig_n,
    input  logic          rem_valid,
    output logic          rem_ready,
    input  logic [RW-1:0] rem_s,
    input  logic [RW-1:0] rem_c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  quot,
`ifdef OTFC_STICKY_EN
    output logic          sticky,
`endif
    output logic          rem_zero
);
    localparam int CW = $clog2(N + 1);
    otfc_state_t state;
    logic [N-1:0] q, qm, q_nxt, qm_nxt;
    logic [CW-1:0] count;
    logic [1:0] dig;
    logic neg, zero;
    assign dig       = {dig_p, dig_n};
    assign busy      = state != IDLE;
    assign dig_ready = state == ACCUM;
    assign rem_ready = state == RESOLVE;
    assign out_valid = state == DONE;
    rem_sign_zero #(.RW(RW)) u_rsz (.s(rem_s), .c(rem_c), .neg(neg), .zero(zero));
    // 2'b11 falls through to the digit-0 update
    always_comb begin
        q_nxt  = dig == DIG_PLUS ? {q[N-2:0], 1'b1} : dig == DIG_MINUS ? {qm[N-2:0], 1'b1} : {q[N-2:0], 1'b0};
        qm_nxt = dig == DIG_PLUS ? {q[N-2:0], 1'b0} : dig == DIG_MINUS ? {qm[N-2:0], 1'b0} : {qm[N-2:0], 1'b1};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            q        <= '0;
            qm       <= '1;
            count    <= '0;
            quot     <= '0;
            rem_zero <= 1'b0;
`ifdef OTFC_STICKY_EN
            sticky   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= ACCUM;
                    q     <= '0;
                    qm    <= '1;
                    count <= '0;
                end
                ACCUM: if (dig_valid) begin
                    q     <= q_nxt;
                    qm    <= qm_nxt;
                    count <= count == CW'(N - 1) ? '0 : count + 1'b1;
                    state <= count == CW'(N - 1) ? RESOLVE : ACCUM;
                end
                RESOLVE: if (rem_valid) begin
                    quot     <= (neg & ~zero) ? qm : q;
                    rem_zero <= zero;
`ifdef OTFC_STICKY_EN
                    sticky   <= ~zero;
`endif
                    state    <= DONE;
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_otfc_quotient_resolver.sv
// tb_otfc_quotient_resolver: directed and random checks of the quotient converter against an arithmetic model
module tb_otfc_quotient_resolver;
    localparam int N  = 4;
    localparam int RW = 8;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic dig_valid = 1'b0, dig_p = 1'b0, dig_n = 1'b0;
    logic rem_valid = 1'b0, out_ready = 1'b0;
    logic [RW-1:0] rem_s = '0, rem_c = '0;
    logic busy, dig_ready, rem_ready, out_valid, rem_zero;
    logic [N-1:0] quot;
    int ncmp = 0, nfail = 0;
`ifdef OTFC_STICKY_EN
    logic sticky;
`endif

    always #5 clk = ~clk;

    otfc_quotient_resolver #(.N(N), .RW(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_p(dig_p), .dig_n(dig_n),
        .rem_valid(rem_valid), .rem_ready(rem_ready), .rem_s(rem_s), .rem_c(rem_c),
        .out_valid(out_valid), .out_ready(out_ready), .quot(quot),
`ifdef OTFC_STICKY_EN
        .sticky(sticky),
`endif
        .rem_zero(rem_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Quotient as a plain signed digit sum mod 2^N, minus one ulp when the remainder is negative
    function automatic logic [N-1:0] model(input logic [2*N-1:0] codes, input logic [RW-1:0] s, input logic [RW-1:0] c);
        int v = 0;
        logic [RW-1:0] sum = s + c;
        for (int i = N - 1; i >= 0; i--)
            v = 2 * v + (codes[2*i+:2] == 2'b10 ? 1 : codes[2*i+:2] == 2'b01 ? -1 : 0);
        if (sum[RW-1]) v--;
        return N'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [1:0] code, input bit poke);
        int k = 0;
        {dig_p, dig_n} = code;
        dig_valid = 1'b1;
        start = poke;
        while (!dig_ready && k < 20) begin
            tick();
            k++;
        end
        check("dig_wait_timeout", 32'(dig_ready), 1);
        tick();
        dig_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_op(input logic [2*N-1:0] codes, input int gap, input bit poke,
                         input logic [RW-1:0] s, input logic [RW-1:0] c,
                         input logic [N-1:0] eq, input logic ez, input int hold);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("dig_ready_latency", 32'(dig_ready), 1);
        for (int i = N - 1; i >= 0; i--) begin
            send_digit(codes[2*i+:2], poke && i == N - 2);
            if (i > 0) repeat (gap) tick();
        end
        check("dig_ready_drop", 32'(dig_ready), 0);
        check("rem_ready_latency", 32'(rem_ready), 1);
        rem_s = s;
        rem_c = c;
        repeat (gap) tick();
        check("rem_ready_hold", 32'(rem_ready), 1);
        rem_valid = 1'b1;
        tick();
        rem_valid = 1'b0;
        check("out_valid_latency", 32'(out_valid), 1);
        check("rem_ready_drop", 32'(rem_ready), 0);
        check("quot", 32'(quot), 32'(eq));
        check("rem_zero", 32'(rem_zero), 32'(ez));
`ifdef OTFC_STICKY_EN
        check("sticky", 32'(sticky), 32'(~ez));
`endif
        for (int h = 0; h < hold; h++) begin
            tick();
            check("out_valid_hold", 32'(out_valid), 1);
            check("quot_hold", 32'(quot), 32'(eq));
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("idle_after_out_ready", 32'(busy), 0);
        check("out_valid_drop", 32'(out_valid), 0);
        tick();
        check("start_in_done_ignored", 32'(busy), 0);
    endtask

    initial begin
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_dig_ready", 32'(dig_ready), 0);
        check("reset_rem_ready", 32'(rem_ready), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_quot", 32'(quot), 0);
        check("reset_rem_zero", 32'(rem_zero), 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("idle_no_start", 32'(busy), 0);
        // digits +1,0,-1,+1
        do_op(8'b10_00_01_10, 0, 1'b0, 8'h10, 8'h00, 4'b0111, 1'b0, 0);
        do_op(8'b10_00_01_10, 0, 1'b0, 8'hF0, 8'h00, 4'b0110, 1'b0, 0);
        do_op(8'b10_00_01_10, 1, 1'b0, 8'h05, 8'hFB, 4'b0111, 1'b1, 0);
        // abort after two digits while the previous result is still held
        start = 1'b1;
        tick();
        start = 1'b0;
        send_digit(2'b10, 1'b0);
        send_digit(2'b00, 1'b0);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_dig_ready", 32'(dig_ready), 0);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_quot", 32'(quot), 0);
        check("abort_rem_zero", 32'(rem_zero), 0);
`ifdef OTFC_STICKY_EN
        check("abort_sticky", 32'(sticky), 0);
`endif
        tick();
        reset = 1'b0;
        tick();
        do_op(8'b10_00_01_10, 0, 1'b0, 8'h10, 8'h00, 4'b0111, 1'b0, 0);
        do_op(8'b01_01_01_01, 2, 1'b1, 8'h01, 8'h02, 4'b0001, 1'b0, 0);
        do_op(8'b01_01_01_01, 2, 1'b1, 8'h80, 8'h01, 4'b0000, 1'b0, 0);
        do_op(8'b10_11_01_10, 0, 1'b0, 8'h20, 8'h00, 4'b0111, 1'b0, 0);
        do_op(8'b10_00_01_10, 0, 1'b0, 8'h10, 8'h00, 4'b0111, 1'b0, 5);
        for (int r = 0; r < 40; r++) begin
            logic [2*N-1:0] codes = (2*N)'($urandom);
            logic [RW-1:0] s = RW'($urandom);
            logic [RW-1:0] c = ($urandom_range(0, 3) == 0) ? RW'(-s) : RW'($urandom);
            logic [RW-1:0] sum = s + c;
            do_op(codes, $urandom_range(0, 2), 1'($urandom), s, c, model(codes, s, c), sum == '0, $urandom_range(0, 3));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
